// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the banked data-memory controller:
// FSM state encoding, selector field helpers and the default DM1..DM3 region map.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_SEL_W       = 4;
  localparam int DEF_OFF_W       = 12;
  localparam int DEF_NUM_REGIONS = 3;
  localparam int DEF_BANKS       = 4;

  localparam int REGION_DM1 = 0;
  localparam int REGION_DM2 = 1;
  localparam int REGION_DM3 = 2;

  // Lowest address bit of the region-select field, which occupies the top of the address.
  function automatic int sel_lsb(input int addr_w, input int sel_w);
    return addr_w - sel_w;
  endfunction

endpackage

// File: rtl/region_decoder.sv
// Combinational region decode: selector -> one-hot region, mapped flag and narrow flag.
module region_decoder
  import mem_ctrl_pkg::*;
#(
  parameter int                     SEL_W       = DEF_SEL_W,
  parameter int                     NUM_REGIONS = DEF_NUM_REGIONS,
  parameter logic [NUM_REGIONS-1:0] NARROW_MASK = 3'b010
) (
  input  logic [SEL_W-1:0]       sel,
  output logic [NUM_REGIONS-1:0] region_onehot,
  output logic                   mapped,
  output logic                   narrow
);

  always_comb begin
    region_onehot = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (sel == SEL_W'(r)) begin
        region_onehot[r] = 1'b1;
      end
    end
    mapped = |region_onehot;
    narrow = |(region_onehot & NARROW_MASK);
  end

endmodule

// File: rtl/banked_memory_controller.sv
// Registered controller between the load/store unit and the DM byte-bank RAMs:
// decodes the region, issues bank strobes, waits out read latency, returns one response per request.
module banked_memory_controller
  import mem_ctrl_pkg::*;
#(
  parameter int                     ADDR_W      = DEF_ADDR_W,
  parameter int                     SEL_W       = DEF_SEL_W,
  parameter int                     OFF_W       = DEF_OFF_W,
  parameter int                     NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int                     BANKS       = DEF_BANKS,
  parameter logic [NUM_REGIONS-1:0] NARROW_MASK = 3'b010,
  parameter int                     RD_LAT      = 1,
  localparam int                    WORD_W      = BANKS * 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req,
  output logic                           ready,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [WORD_W-1:0]              wdata,
  input  logic [BANKS-1:0]               be,
  output logic                           resp_valid,
  output logic                           resp_err,
  output logic [WORD_W-1:0]              rdata,
  output logic [NUM_REGIONS-1:0]         mem_en,
  output logic [NUM_REGIONS*BANKS-1:0]   mem_wren,
  output logic [OFF_W-1:0]               mem_addr,
  output logic [WORD_W-1:0]              mem_wdata,
  input  logic [NUM_REGIONS*BANKS*8-1:0] mem_q
);

  localparam int CNT_W   = $clog2(RD_LAT + 1);
  localparam int SEL_LSB = sel_lsb(ADDR_W, SEL_W);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [OFF_W-1:0]       off_q, off_d;
  logic [WORD_W-1:0]      wdata_q, wdata_d;
  logic [BANKS-1:0]       be_q, be_d;
  logic [NUM_REGIONS-1:0] region_q, region_d;
  logic                   narrow_q, narrow_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]      rdata_q, rdata_d;

  logic [NUM_REGIONS-1:0] dec_onehot;
  logic                   dec_mapped;
  logic                   dec_narrow;
  logic [WORD_W-1:0]      raw_word;
  logic [WORD_W-1:0]      read_word;
  logic                   strobe_active;

  region_decoder #(
    .SEL_W       (SEL_W),
    .NUM_REGIONS (NUM_REGIONS),
    .NARROW_MASK (NARROW_MASK)
  ) u_region_decoder (
    .sel           (addr[ADDR_W-1:SEL_LSB]),
    .region_onehot (dec_onehot),
    .mapped        (dec_mapped),
    .narrow        (dec_narrow)
  );

  // Region read mux; narrow regions only have bank 0, replicated across every lane.
  always_comb begin
    raw_word = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (region_q[r]) begin
        raw_word = raw_word | mem_q[r*WORD_W +: WORD_W];
      end
    end
    read_word = narrow_q ? {BANKS{raw_word[7:0]}} : raw_word;
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    region_d = region_q;
    narrow_d = narrow_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d     = we;
          off_d    = addr[OFF_W-1:0];
          wdata_d  = wdata;
          be_d     = be;
          region_d = dec_onehot;
          narrow_d = dec_narrow;
          err_d    = !dec_mapped;
          state_d  = dec_mapped ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = read_word;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state, so reset drives every strobe low at once.
  always_comb begin
    strobe_active = (state_q == ISSUE) || (state_q == WAIT);
    ready         = (state_q == IDLE);
    resp_valid    = (state_q == RESP);
    resp_err      = resp_valid && err_q;
    rdata         = resp_err ? '0 : rdata_q;
    mem_en        = strobe_active ? region_q : '0;
    mem_addr      = strobe_active ? off_q : '0;
    mem_wdata     = '0;
    mem_wren      = '0;
    if ((state_q == ISSUE) && we_q) begin
      mem_wdata = narrow_q ? WORD_W'(wdata_q[7:0]) : wdata_q;
      for (int r = 0; r < NUM_REGIONS; r++) begin
        for (int b = 0; b < BANKS; b++) begin
          if (region_q[r]) begin
            mem_wren[r*BANKS+b] = narrow_q ? ((b == 0) && be_q[0]) : be_q[b];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      region_q <= '0;
      narrow_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      region_q <= region_d;
      narrow_q <= narrow_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
